// File: rtl/rf_ctrl_pkg.sv
// Shared widths and the write-request payload used by the register-file
// write scheduler and its memory-return buffer.
package rf_ctrl_pkg;

    localparam int unsigned REG_ID_W = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned DATA_W   = 16;

    // One register-file write: destination register plus data
    typedef struct packed {
        logic [REG_ID_W-1:0] reg_id;
        logic [DATA_W-1:0]   data;
    } rf_wreq_t;

endpackage

// File: rtl/rf_ret_fifo.sv
// In-order circular buffer for late memory-return writes.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data enqueue one entry (ignored when full)
//   pop             dequeue the head entry (ignored when empty)
//   head            current head entry (valid when !empty)
//   full, empty     derived from the registered occupancy count
module rf_ret_fifo
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  rf_wreq_t push_data,
    input  logic     pop,
    output rf_wreq_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rf_wreq_t           mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the register file's single write port between the pipeline
// writeback stage and a buffered late memory-return path, and keeps a
// scoreboard of registers awaiting load-miss data.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   wb_valid/wb_reg/wb_data     writeback request (always wins the port)
//   mr_valid/mr_reg/mr_data     memory-return offer; mr_ready accepts it
//   pend_set/pend_reg           mark a register pending on a load miss
//   chk_src1/chk_src2/chk_dst   decode operands; hazard if any pending
//   wb_stall                    registered request to hold writeback off
//   rf_write/rf_reg/rf_data     register-file write port
module rf_write_scheduler
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid,
    input  logic [REG_ID_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                mr_valid,
    input  logic [REG_ID_W-1:0] mr_reg,
    input  logic [DATA_W-1:0]   mr_data,
    output logic                mr_ready,
    input  logic                pend_set,
    input  logic [REG_ID_W-1:0] pend_reg,
    input  logic [REG_ID_W-1:0] chk_src1,
    input  logic [REG_ID_W-1:0] chk_src2,
    input  logic [REG_ID_W-1:0] chk_dst,
    output logic                hazard,
    output logic                wb_stall,
    output logic                rf_write,
    output logic [REG_ID_W-1:0] rf_reg,
    output logic [DATA_W-1:0]   rf_data
);

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

    rf_wreq_t             mr_req;
    rf_wreq_t             head;
    rf_wreq_t             sel;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 drain;
    logic [NUM_REGS-1:0]  pend;
    logic [NUM_REGS-1:0]  pend_next;
    logic [SC_W-1:0]      starve_cnt;
    logic [SC_W-1:0]      starve_next;

    always_comb begin
        mr_req        = '0;
        mr_req.reg_id = mr_reg;
        mr_req.data   = mr_data;
    end

    assign mr_ready = !full;
    assign push     = mr_valid && mr_ready;
    // The buffer only drains on cycles writeback leaves the port idle
    assign drain    = !wb_valid && !empty;

    rf_ret_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mr_req),
        .pop       (drain),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Port mux; register 0 is hardwired so its writes are suppressed
    always_comb begin
        sel = head;
        if (wb_valid) begin
            sel.reg_id = wb_reg;
            sel.data   = wb_data;
        end
    end

    assign rf_write = !rst && (wb_valid || !empty) && (sel.reg_id != '0);
    assign rf_reg   = sel.reg_id;
    assign rf_data  = sel.data;

    // Scoreboard: a same-register set overrides the drain clear
    always_comb begin
        pend_next = pend;
        if (drain) begin
            pend_next[head.reg_id] = 1'b0;
        end
        if (pend_set) begin
            pend_next[pend_reg] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    assign hazard = pend[chk_src1] | pend[chk_src2] | pend[chk_dst];

    // Blocked-head counter, saturating at the limit
    always_comb begin
        starve_next = starve_cnt;
        if (empty || drain) begin
            starve_next = '0;
        end else if (wb_valid && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
            starve_next = starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            pend       <= pend_next;
            starve_cnt <= starve_next;
            if (drain) begin
                wb_stall <= 1'b0;
            end else if (starve_next == SC_W'(STARVE_LIMIT)) begin
                wb_stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: reset, writeback pass-through,
// load-miss scoreboard, buffer ordering/full, starvation, register 0,
// set/clear collision and reset mid-operation.
module tb_rf_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        mr_valid;
    logic [3:0]  mr_reg;
    logic [15:0] mr_data;
    logic        mr_ready;
    logic        pend_set;
    logic [3:0]  pend_reg;
    logic [3:0]  chk_src1;
    logic [3:0]  chk_src2;
    logic [3:0]  chk_dst;
    logic        hazard;
    logic        wb_stall;
    logic        rf_write;
    logic [3:0]  rf_reg;
    logic [15:0] rf_data;

    int vectors = 0;
    int miscompares = 0;

    rf_write_scheduler #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .mr_valid (mr_valid),
        .mr_reg   (mr_reg),
        .mr_data  (mr_data),
        .mr_ready (mr_ready),
        .pend_set (pend_set),
        .pend_reg (pend_reg),
        .chk_src1 (chk_src1),
        .chk_src2 (chk_src2),
        .chk_dst  (chk_dst),
        .hazard   (hazard),
        .wb_stall (wb_stall),
        .rf_write (rf_write),
        .rf_reg   (rf_reg),
        .rf_data  (rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        mr_valid = 1'b0; mr_reg = '0; mr_data = '0;
        pend_set = 1'b0; pend_reg = '0;
        chk_src1 = '0; chk_src2 = '0; chk_dst = '0;

        // Reset values
        tick(); tick();
        settle();
        chk("rst_mr_ready", 32'(mr_ready), 32'd1);
        chk("rst_wb_stall", 32'(wb_stall), 32'd0);
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_hazard",   32'(hazard),   32'd0);
        rst = 1'b0;
        tick();

        // WB pass-through
        wb_valid = 1'b1; wb_reg = 4'd5; wb_data = 16'hBEEF;
        settle();
        chk("wb_rf_write", 32'(rf_write), 32'd1);
        chk("wb_rf_reg",   32'(rf_reg),   32'd5);
        chk("wb_rf_data",  32'(rf_data),  32'hBEEF);
        tick();
        wb_reg = 4'd0; wb_data = 16'h5555;
        settle();
        chk("wb_r0_rf_write", 32'(rf_write), 32'd0);
        tick();
        wb_valid = 1'b0;

        // Load-miss return on R3
        pend_set = 1'b1; pend_reg = 4'd3; chk_src1 = 4'd3;
        settle();
        chk("pend_not_yet", 32'(hazard), 32'd0);
        tick();
        pend_set = 1'b0;
        settle();
        chk("pend_src1_hazard", 32'(hazard), 32'd1);
        chk_src1 = 4'd1; chk_dst = 4'd3;
        settle();
        chk("pend_dst_hazard", 32'(hazard), 32'd1);
        chk_dst = 4'd0; chk_src2 = 4'd2;
        settle();
        chk("pend_other_clear", 32'(hazard), 32'd0);
        chk_src2 = 4'd0; chk_src1 = 4'd3;
        mr_valid = 1'b1; mr_reg = 4'd3; mr_data = 16'h1234;
        settle();
        chk("mr_no_fallthru", 32'(rf_write), 32'd0);
        chk("mr_ready_empty", 32'(mr_ready), 32'd1);
        tick();
        mr_valid = 1'b0;
        settle();
        chk("mr_drain_write", 32'(rf_write), 32'd1);
        chk("mr_drain_reg",   32'(rf_reg),   32'd3);
        chk("mr_drain_data",  32'(rf_data),  32'h1234);
        chk("mr_hazard_hold", 32'(hazard),   32'd1);
        tick();
        settle();
        chk("mr_after_write", 32'(rf_write), 32'd0);
        chk("mr_hazard_clr",  32'(hazard),   32'd0);
        chk_src1 = 4'd0;

        // Conflict and full buffer
        wb_valid = 1'b1; wb_reg = 4'd1; wb_data = 16'h1111;
        mr_valid = 1'b1; mr_reg = 4'd4; mr_data = 16'h4444;
        settle();
        chk("cf_wb_wins", 32'(rf_reg), 32'd1);
        tick();
        mr_reg = 4'd6; mr_data = 16'h6666;
        settle();
        chk("cf_ready_one", 32'(mr_ready), 32'd1);
        chk("cf_wb_data",   32'(rf_data),  32'h1111);
        tick();
        mr_valid = 1'b0;
        settle();
        chk("cf_full", 32'(mr_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("cf_first_write", 32'(rf_write), 32'd1);
        chk("cf_first_reg",   32'(rf_reg),   32'd4);
        chk("cf_first_data",  32'(rf_data),  32'h4444);
        chk("cf_still_full",  32'(mr_ready), 32'd0);
        tick();
        settle();
        chk("cf_second_reg",  32'(rf_reg),   32'd6);
        chk("cf_second_data", 32'(rf_data),  32'h6666);
        chk("cf_ready_again", 32'(mr_ready), 32'd1);
        tick();
        settle();
        chk("cf_drained", 32'(rf_write), 32'd0);

        // Starvation
        wb_valid = 1'b1; wb_reg = 4'd2; wb_data = 16'h2222;
        mr_valid = 1'b1; mr_reg = 4'd8; mr_data = 16'h8888;
        tick();
        mr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("st_no_stall_yet", 32'(wb_stall), 32'd0);
            tick();
        end
        settle();
        chk("st_stall_set", 32'(wb_stall), 32'd1);
        chk("st_wb_wins",   32'(rf_reg),   32'd2);
        tick();
        settle();
        chk("st_stall_hold", 32'(wb_stall), 32'd1);
        wb_valid = 1'b0;
        settle();
        chk("st_drain_reg",     32'(rf_reg),   32'd8);
        chk("st_drain_data",    32'(rf_data),  32'h8888);
        chk("st_stall_pre_clr", 32'(wb_stall), 32'd1);
        tick();
        settle();
        chk("st_stall_clr", 32'(wb_stall), 32'd0);
        chk("st_empty",     32'(rf_write), 32'd0);

        // Register 0 return is popped without a write
        wb_valid = 1'b1; wb_reg = 4'd1; wb_data = 16'h0101;
        mr_valid = 1'b1; mr_reg = 4'd0; mr_data = 16'hABCD;
        tick();
        mr_reg = 4'd10; mr_data = 16'hAAAA;
        tick();
        mr_valid = 1'b0; wb_valid = 1'b0;
        settle();
        chk("r0_no_write", 32'(rf_write), 32'd0);
        tick();
        settle();
        chk("r0_next_write", 32'(rf_write), 32'd1);
        chk("r0_next_reg",   32'(rf_reg),   32'd10);
        tick();

        // pend_set to register 0 is ignored
        pend_set = 1'b1; pend_reg = 4'd0;
        tick();
        pend_set = 1'b0;
        settle();
        chk("r0_pend_ignored", 32'(hazard), 32'd0);

        // Set/clear collision on R7
        pend_set = 1'b1; pend_reg = 4'd7;
        tick();
        pend_set = 1'b0;
        mr_valid = 1'b1; mr_reg = 4'd7; mr_data = 16'h7777;
        tick();
        mr_valid = 1'b0;
        pend_set = 1'b1; pend_reg = 4'd7;
        settle();
        chk("col_drain_reg", 32'(rf_reg), 32'd7);
        tick();
        pend_set = 1'b0; chk_src1 = 4'd7;
        settle();
        chk("col_set_wins", 32'(hazard), 32'd1);

        // Reset mid-operation discards buffer and pending bits
        wb_valid = 1'b1; wb_reg = 4'd5; wb_data = 16'h5A5A;
        mr_valid = 1'b1; mr_reg = 4'd9; mr_data = 16'h9999;
        pend_set = 1'b1; pend_reg = 4'd9;
        tick();
        mr_valid = 1'b0; pend_set = 1'b0; chk_src1 = 4'd9;
        settle();
        chk("mid_hazard_r9", 32'(hazard), 32'd1);
        rst = 1'b1;
        settle();
        chk("mid_rst_write",  32'(rf_write), 32'd0);
        chk("mid_rst_ready",  32'(mr_ready), 32'd1);
        chk("mid_rst_stall",  32'(wb_stall), 32'd0);
        chk("mid_rst_hazard", 32'(hazard),   32'd0);
        tick();
        rst = 1'b0; wb_valid = 1'b0; chk_src2 = 4'd7;
        settle();
        chk("post_rst_empty",  32'(rf_write), 32'd0);
        chk("post_rst_hazard", 32'(hazard),   32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
